// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
//
// Round-robin arbiter that merges p_n valid/ready streams onto one downstream
// stream. A requester keeps its grant for up to p_burst transfers. The grant
// ends early if the requester drops valid. Exactly one IDLE cycle separates
// consecutive grants. Data, valid and ready are combinational pass-throughs
// of the granted requester. Only the grant bookkeeping is registered.
//
// Ports
//   i_clk    : clock; all logic is rising-edge
//   i_rst    : synchronous, active-high reset
//   i_valid  : [p_n]          per-requester valid
//   i_data   : [p_n*p_width]  requester k at bits [k*p_width +: p_width]
//   o_ready  : [p_n]          per-requester ready (only the granted bit can be 1)
//   o_valid  : downstream valid
//   o_data   : [p_width]      downstream data (don't-care when o_valid=0)
//   o_id     : [p_idw]        index of the granted requester
//   o_last   : final transfer of the current grant
//   i_ready  : downstream ready
// -----------------------------------------------------------------------------
module stream_rr_arbiter #(
   parameter int p_n     = 4,
   parameter int p_width = 16,
   parameter int p_burst = 8,
   localparam int p_idw  = (p_n > 1) ? $clog2(p_n) : 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [p_n-1:0]           i_valid,
   input  logic [p_n*p_width-1:0]   i_data,
   output logic [p_n-1:0]           o_ready,
   output logic                     o_valid,
   output logic [p_width-1:0]       o_data,
   output logic [p_idw-1:0]         o_id,
   output logic                     o_last,
   input  logic                     i_ready
);

   localparam int p_cw = $clog2(p_burst + 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [p_idw-1:0] r_grant;
   logic [p_idw-1:0] w_grant_nxt;
   logic [p_idw-1:0] r_ptr;
   logic [p_idw-1:0] w_ptr_nxt;
   logic [p_cw-1:0]  r_cnt;
   logic [p_cw-1:0]  w_cnt_nxt;

   logic [p_n-1:0]   w_rot;
   logic [p_idw-1:0] w_sel;
   logic             w_found;
   logic             w_gvalid;
   logic             w_xfer;
   logic             w_last;
   logic [p_idw-1:0] w_grant_inc;

   // Rotated request vector and first-set search starting at the rr pointer.
   // After rotation, bit i corresponds to requester (r_ptr + i) mod p_n.
   always_comb begin
      logic [p_idw:0] v_sum;
      w_found = 1'b0;
      w_sel   = '0;
      v_sum   = '0;
      w_rot   = p_n'({i_valid, i_valid} >> r_ptr);
      for (int i = 0; i < p_n; i++) begin
         if (!w_found && w_rot[i]) begin
            w_found = 1'b1;
            v_sum   = {1'b0, r_ptr} + (p_idw+1)'(i);
            if (v_sum >= (p_idw+1)'(p_n)) begin
               v_sum = v_sum - (p_idw+1)'(p_n);
            end else begin
               v_sum = v_sum;
            end
            w_sel = v_sum[p_idw-1:0];
         end else begin
            w_found = w_found;
         end
      end
   end

   // Pass-through of the granted requester and burst-end detection.
   always_comb begin
      w_gvalid    = i_valid[r_grant];
      o_data      = p_width'(i_data >> (int'(r_grant) * p_width));
      o_id        = r_grant;
      w_grant_inc = (r_grant == p_idw'(p_n - 1)) ? '0 : r_grant + p_idw'(1);
      if (r_state == S_GRANT) begin
         o_valid = w_gvalid;
         o_ready = {{(p_n-1){1'b0}}, i_ready} << r_grant;
      end else begin
         o_valid = 1'b0;
         o_ready = '0;
      end
      w_last = o_valid && (r_cnt == p_cw'(p_burst - 1));
      o_last = w_last;
      w_xfer = o_valid && i_ready;
   end

   // Next-state logic: pick a grant in IDLE, count transfers and release in GRANT.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_GRANT;
               w_grant_nxt = w_sel;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_GRANT: begin
            // A dropped valid releases the grant without a transfer; a
            // stalled-but-valid requester keeps it.
            if (!w_gvalid) begin
               w_state_nxt = S_IDLE;
               w_ptr_nxt   = w_grant_inc;
            end else if (w_xfer && w_last) begin
               w_state_nxt = S_IDLE;
               w_ptr_nxt   = w_grant_inc;
            end else if (w_xfer) begin
               w_cnt_nxt   = r_cnt + p_cw'(1);
            end else begin
               w_state_nxt = S_GRANT;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, grant, pointer and burst-counter registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_rr_arbiter
//
// Directed bench for stream_rr_arbiter. It uses two instances:
//   u_dut_a : p_n=4, p_width=16, p_burst=8
//   u_dut_b : p_n=2, p_width=16, p_burst=1
// Each cycle the expected outputs are pushed to a scoreboard queue as the
// stimulus is applied. They are popped and compared on the falling edge.
// Requester k drives {tag nibble, 12-bit word count}. The count advances only
// when the bench's own expectation says that word was transferred.
// -----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

   logic        clk = 1'b0;
   logic        i_rst;

   logic [3:0]  valid_a;
   logic [63:0] data_a;
   logic [3:0]  rdy_a;
   logic        ov_a;
   logic [15:0] od_a;
   logic [1:0]  oid_a;
   logic        ol_a;
   logic        ir_a;

   logic [1:0]  valid_b;
   logic [31:0] data_b;
   logic [1:0]  rdy_b;
   logic        ov_b;
   logic [15:0] od_b;
   logic [0:0]  oid_b;
   logic        ol_b;
   logic        ir_b;

   typedef struct {
      int          sel;
      logic        v;
      logic [3:0]  id;
      logic        l;
      logic [3:0]  rdy;
      logic [15:0] d;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   wcnt_a[4];
   int   wcnt_b[2];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   order[5] = '{0, 1, 2, 3, 0};

   always #5 clk = ~clk;

   stream_rr_arbiter #(.p_n(4), .p_width(16), .p_burst(8)) u_dut_a (
      .i_clk(clk), .i_rst(i_rst), .i_valid(valid_a), .i_data(data_a),
      .o_ready(rdy_a), .o_valid(ov_a), .o_data(od_a), .o_id(oid_a),
      .o_last(ol_a), .i_ready(ir_a)
   );

   stream_rr_arbiter #(.p_n(2), .p_width(16), .p_burst(1)) u_dut_b (
      .i_clk(clk), .i_rst(i_rst), .i_valid(valid_b), .i_data(data_b),
      .o_ready(rdy_b), .o_valid(ov_b), .o_data(od_b), .o_id(oid_b),
      .o_last(ol_b), .i_ready(ir_b)
   );

   task automatic refresh();
      for (int k = 0; k < 4; k++) data_a[k*16 +: 16] = {4'(k), 12'(wcnt_a[k])};
      for (int k = 0; k < 2; k++) data_b[k*16 +: 16] = {4'(k + 8), 12'(wcnt_b[k])};
   endtask

   task automatic check(input string tag, input string field,
                        input logic [15:0] obs, input logic [15:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp_v);
      end
   endtask

   // One clock cycle: push expectation, compare at negedge, model the transfer.
   task automatic tick(input int sel, input logic ev, input int eid,
                       input logic el, input logic [3:0] erdy, input string tag);
      exp_t e;
      logic rdy_now;
      e.sel = sel;
      e.v   = ev;
      e.id  = 4'(eid);
      e.l   = el;
      e.rdy = erdy;
      e.tag = tag;
      if (sel == 0) e.d = {4'(eid), 12'(wcnt_a[eid])};
      else          e.d = {4'(eid + 8), 12'(wcnt_b[eid])};
      sb_q.push_back(e);
      @(negedge clk);
      e = sb_q.pop_front();
      if (e.sel == 0) begin
         check(e.tag, "valid", 16'(ov_a), 16'(e.v));
         check(e.tag, "id", 16'(oid_a), 16'(e.id));
         check(e.tag, "last", 16'(ol_a), 16'(e.l));
         check(e.tag, "ready", 16'(rdy_a), 16'(e.rdy));
         if (e.v) check(e.tag, "data", od_a, e.d);
         rdy_now = ir_a;
      end else begin
         check(e.tag, "valid", 16'(ov_b), 16'(e.v));
         check(e.tag, "id", 16'(oid_b), 16'(e.id));
         check(e.tag, "last", 16'(ol_b), 16'(e.l));
         check(e.tag, "ready", 16'(rdy_b), 16'(e.rdy));
         if (e.v) check(e.tag, "data", od_b, e.d);
         rdy_now = ir_b;
      end
      @(posedge clk);
      if (ev && rdy_now) begin
         if (sel == 0) wcnt_a[eid] = (wcnt_a[eid] + 1) % 4096;
         else          wcnt_b[eid] = (wcnt_b[eid] + 1) % 4096;
      end
      #1;
      refresh();
   endtask

   task automatic do_reset();
      i_rst   = 1'b1;
      valid_a = '0;
      valid_b = '0;
      ir_a    = 1'b0;
      ir_b    = 1'b0;
      @(posedge clk);
      #1;
      i_rst   = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 4; k++) wcnt_a[k] = 16 * k;
      for (int k = 0; k < 2; k++) wcnt_b[k] = 100 * k;
      refresh();
      do_reset();

      // Single requester 2: 8-word burst, one idle cycle, regrant.
      valid_a = 4'b0100;
      ir_a    = 1'b1;
      tick(0, 1'b0, 0, 1'b0, 4'b0000, "rst_state");
      for (int j = 0; j < 8; j++) tick(0, 1'b1, 2, (j == 7), 4'b0100, "single");
      tick(0, 1'b0, 2, 1'b0, 4'b0000, "single_idle");
      tick(0, 1'b1, 2, 1'b0, 4'b0100, "single_regrant");

      // Round robin over all four requesters.
      do_reset();
      valid_a = 4'b1111;
      ir_a    = 1'b1;
      tick(0, 1'b0, 0, 1'b0, 4'b0000, "rr_idle0");
      for (int g = 0; g < 5; g++) begin
         for (int j = 0; j < 8; j++)
            tick(0, 1'b1, order[g], (j == 7), 4'(1 << order[g]), "rr_burst");
         if (g < 4) tick(0, 1'b0, order[g], 1'b0, 4'b0000, "rr_idle");
      end

      // Downstream stall mid-burst on requester 1.
      do_reset();
      valid_a = 4'b0010;
      ir_a    = 1'b1;
      tick(0, 1'b0, 0, 1'b0, 4'b0000, "stall_idle");
      for (int j = 0; j < 3; j++) tick(0, 1'b1, 1, 1'b0, 4'b0010, "stall_pre");
      ir_a = 1'b0;
      for (int j = 0; j < 5; j++) tick(0, 1'b1, 1, 1'b0, 4'b0000, "stall_hold");
      ir_a = 1'b1;
      for (int j = 3; j < 8; j++) tick(0, 1'b1, 1, (j == 7), 4'b0010, "stall_post");
      tick(0, 1'b0, 1, 1'b0, 4'b0000, "stall_end_idle");
      tick(0, 1'b1, 1, 1'b0, 4'b0010, "stall_regrant");

      // Early release by requester 3; others toggling are ignored in GRANT.
      do_reset();
      valid_a = 4'b1000;
      ir_a    = 1'b1;
      tick(0, 1'b0, 0, 1'b0, 4'b0000, "early_idle");
      valid_a = 4'b1011;
      for (int j = 0; j < 3; j++) tick(0, 1'b1, 3, 1'b0, 4'b1000, "early_xfer");
      valid_a = 4'b0011;
      tick(0, 1'b0, 3, 1'b0, 4'b1000, "early_drop");
      tick(0, 1'b0, 3, 1'b0, 4'b0000, "early_idle2");
      tick(0, 1'b1, 0, 1'b0, 4'b0001, "early_next");

      // Reset in the middle of a requester-2 burst.
      do_reset();
      valid_a = 4'b0100;
      ir_a    = 1'b1;
      tick(0, 1'b0, 0, 1'b0, 4'b0000, "mrst_idle");
      for (int j = 0; j < 4; j++) tick(0, 1'b1, 2, 1'b0, 4'b0100, "mrst_xfer");
      valid_a = 4'b0101;
      i_rst   = 1'b1;
      tick(0, 1'b1, 2, 1'b0, 4'b0100, "mrst_edge");
      i_rst   = 1'b0;
      tick(0, 1'b0, 0, 1'b0, 4'b0000, "mrst_after");
      tick(0, 1'b1, 0, 1'b0, 4'b0001, "mrst_grant0");

      // p_burst=1, two requesters: alternating single-word grants.
      do_reset();
      valid_b = 2'b11;
      ir_b    = 1'b1;
      tick(1, 1'b0, 0, 1'b0, 4'b0000, "b1_idle0");
      for (int j = 0; j < 4; j++) begin
         tick(1, 1'b1, j % 2, 1'b1, 4'(1 << (j % 2)), "b1_xfer");
         tick(1, 1'b0, j % 2, 1'b0, 4'b0000, "b1_idle");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter p_n, default 4: number of requesting streams, 2..16.
REQ-002 SHALL have parameter p_width, default 16: data width per stream; output width is p_width.
REQ-003 SHALL have parameter p_burst, default 8: maximum transfers per grant, >=1.
REQ-004 SHALL have derived localparam p_idw = max(1, $clog2(p_n)): requester-id width.
REQ-005 SHALL have port i_clk, input, 1: sole clock; all logic rising-edge.
REQ-006 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port i_valid, input, p_n: per-requester valid.
REQ-008 SHALL have port i_data, input, p_n*p_width: requester k occupies bits [k*p_width +: p_width].
REQ-009 SHALL have port o_ready, output, p_n: per-requester ready.
REQ-010 SHALL have port o_valid, output, 1: downstream valid.
REQ-011 SHALL have port o_data, output, p_width: downstream data, feeds the width adapter.
REQ-012 SHALL have port o_id, output, p_idw: index of the granted requester.
REQ-013 SHALL have port o_last, output, 1: marks final transfer of a grant.
REQ-014 SHALL have port i_ready, input, 1: downstream ready.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-016 SHALL define a transfer as a cycle with o_valid & i_ready.
REQ-017 SHALL, in IDLE with any i_valid bit set, select the first set bit at or above rr_ptr, searching upward modulo p_n, register it as grant, clear the burst counter, and go to GRANT.
REQ-018 SHALL, in IDLE, drive o_valid=0, o_ready=0, o_last=0.
REQ-019 SHALL, in GRANT, pass through combinationally: o_valid=i_valid[grant], o_data=i_data slice of grant, o_ready[grant]=i_ready, all other o_ready bits 0.
REQ-020 SHALL drive o_id=grant in all states; o_data is don't-care when o_valid=0.
REQ-021 SHALL increment a burst counter of width $clog2(p_burst+1) on each transfer in GRANT.
REQ-022 SHALL assert o_last in GRANT when o_valid=1 and counter==p_burst-1.
REQ-023 SHALL return to IDLE on a transfer with o_last=1.
REQ-024 SHALL return to IDLE, without a transfer, on any GRANT cycle with i_valid[grant]=0. A requester holding valid while downstream stalls keeps the grant.
REQ-025 SHALL set rr_ptr=(grant+1) mod p_n on every GRANT->IDLE transition.
REQ-026 SHALL ignore i_valid changes of non-granted requesters while in GRANT.
REQ-027 SHALL incur exactly one IDLE cycle between consecutive grants: request at cycle t, earliest o_valid at t+1.
REQ-028 SHALL never accept data from a requester with o_ready low, and never drop or duplicate a word.
REQ-029 SHALL, with p_burst=1, assert o_last on every valid GRANT cycle.

Reset
REQ-030 SHALL, while i_rst=1 at a clock edge, force state=IDLE, rr_ptr=0, grant=0, counter=0.
REQ-031 SHALL, in the cycle after reset, drive o_valid=0, o_ready=0, o_last=0, o_id=0.
REQ-032 SHALL, if reset asserts mid-burst, abort the burst with no further o_ready; the next grant restarts from requester 0.

Verification
REQ-033 SHALL cover single requester: p_n=4, p_burst=8, only i_valid[2] held with i_ready=1 -> 8 consecutive transfers, o_id=2, o_last on the 8th, one IDLE cycle, then regrant to 2.
REQ-034 SHALL cover round-robin: all four valid continuously, i_ready=1 -> grant order 0,1,2,3,0, each 8 words with one idle cycle between grants.
REQ-035 SHALL cover downstream stall: granted requester 1, i_ready low for 5 cycles mid-burst -> o_valid held, counter frozen, data stable, burst completes with exactly 8 transfers.
REQ-036 SHALL cover early release: requester 3 drops valid after 3 transfers -> GRANT->IDLE, no o_last, rr_ptr=0, next grant to the lowest valid index >=0.
REQ-037 SHALL cover reset mid-burst: i_rst pulsed after 4 transfers of requester 2 -> next cycle o_ready=0, o_valid=0, then grant to requester 0 if valid.
REQ-038 SHALL cover p_burst=1 with p_n=2, both valid -> alternating ids 0,1,0,1, o_last on every transfer, one idle cycle between transfers.
